// File: rtl/relogio_pkg.sv
// Shared definitions for the clock core and its adjustment controller:
// field limits, the time-field type and the adjustment-state encoding.
package relogio_pkg;

   localparam int unsigned TIME_W = 6;

   typedef logic [TIME_W-1:0] time_t;

   localparam time_t MAX_SEG  = 6'd59;
   localparam time_t MAX_MIN  = 6'd59;
   localparam time_t MAX_HORA = 6'd23;

   typedef enum logic [1:0] {
      AJ_NORMAL   = 2'd0,
      AJ_HORAS    = 2'd1,
      AJ_MINUTOS  = 2'd2,
      AJ_SEGUNDOS = 2'd3
   } estado_ajuste_t;

   // Out-of-range load values collapse to zero so field invariants always hold.
   function automatic time_t limita(input time_t valor, input time_t maximo);
      return (valor > maximo) ? '0 : valor;
   endfunction

endpackage

// File: rtl/contador_relogio_divisor_tick.sv
// Prescaler: divides the system clock down to a one-cycle advance enable
// every TICK_DIV running cycles; freezes on hold, restarts on clear.
module divisor_tick #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned PRESC_W  = $clog2(TICK_DIV)
) (
   input  logic clk_100MHz,
   input  logic rst,
   input  logic hold,
   input  logic clear,
   output logic en
);

   localparam logic [PRESC_W-1:0] CNT_MAX = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_fim;

   assign w_fim = (r_cnt == CNT_MAX);
   assign en    = w_fim & ~hold & ~clear;

   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (hold) begin
         r_cnt <= r_cnt;
      end else if (w_fim) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/contador_relogio.sv
// Timekeeping core: HH:MM:SS cascade advanced by the 1 Hz enable, with
// range-checked load taking priority over pause and advance.
module contador_relogio
   import relogio_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned PRESC_W  = $clog2(TICK_DIV)
) (
   input  logic              clk_100MHz,
   input  logic              rst,
   input  logic              pause,
   input  logic              load,
   input  logic [TIME_W-1:0] segundos_load,
   input  logic [TIME_W-1:0] minutos_load,
   input  logic [TIME_W-1:0] horas_load,
   output logic [TIME_W-1:0] segundos,
   output logic [TIME_W-1:0] minutos,
   output logic [TIME_W-1:0] horas,
   output logic              tick_1hz,
   output logic              dia_completo
);

   time_t r_seg;
   time_t r_min;
   time_t r_hora;
   logic  r_tick;
   logic  r_dia;

   logic  w_en;
   logic  w_seg_fim;
   logic  w_min_fim;
   logic  w_hora_fim;

   divisor_tick #(
      .TICK_DIV (TICK_DIV),
      .PRESC_W  (PRESC_W)
   ) u_divisor (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .hold       (pause),
      .clear      (load),
      .en         (w_en)
   );

   assign w_seg_fim  = (r_seg  == MAX_SEG);
   assign w_min_fim  = (r_min  == MAX_MIN);
   assign w_hora_fim = (r_hora == MAX_HORA);

   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         r_seg  <= '0;
         r_min  <= '0;
         r_hora <= '0;
         r_tick <= 1'b0;
         r_dia  <= 1'b0;
      end else if (load) begin
         r_seg  <= limita(segundos_load, MAX_SEG);
         r_min  <= limita(minutos_load,  MAX_MIN);
         r_hora <= limita(horas_load,    MAX_HORA);
         r_tick <= 1'b0;
         r_dia  <= 1'b0;
      end else if (w_en) begin
         // Each field only moves when every lower field wraps.
         r_seg  <= w_seg_fim ? '0 : r_seg + 1'b1;
         if (w_seg_fim) begin
            r_min <= w_min_fim ? '0 : r_min + 1'b1;
            if (w_min_fim) begin
               r_hora <= w_hora_fim ? '0 : r_hora + 1'b1;
            end
         end
         r_tick <= 1'b1;
         r_dia  <= w_seg_fim & w_min_fim & w_hora_fim;
      end else begin
         r_tick <= 1'b0;
         r_dia  <= 1'b0;
      end
   end

   assign segundos     = r_seg;
   assign minutos      = r_min;
   assign horas        = r_hora;
   assign tick_1hz     = r_tick;
   assign dia_completo = r_dia;

endmodule

// File: doc/contador_relogio.md
Name: contador_relogio

Overview:
Timekeeping core of the clock, directly downstream of the adjustment controller. It consumes that controller's pause, load and adjusted seconds/minutes/hours. It produces the running HH:MM:SS, which is fed back to the controller's *_in inputs and to the display path. A 1 Hz enable is derived from the 100 MHz system clock by an internal prescaler.

Parameters:
TICK_DIV, 100000000, clk_100MHz cycles per second; must be >= 2; simulation benches use 4.
PRESC_W, $clog2(TICK_DIV), prescaler counter width.

Ports:
clk_100MHz  input  1  system clock, 100 MHz
rst  input  1  reset, synchronous, active-high
pause  input  1  level; high holds time and prescaler (adjustment in progress)
load  input  1  one-cycle pulse; loads *_load values
segundos_load  input  6  seconds value to load
minutos_load  input  6  minutes value to load
horas_load  input  6  hours value to load
segundos  output  6  current seconds, 0..59, registered
minutos  output  6  current minutes, 0..59, registered
horas  output  6  current hours, 0..23, registered
tick_1hz  output  1  one-cycle pulse, high in the cycle the time advances
dia_completo  output  1  one-cycle pulse, high in the cycle 23:59:59 wraps to 00:00:00

Behaviour:
- Clock and reset: one clock domain, clk_100MHz. Reset is synchronous and active-high (rst). All registers update only on the rising edge of clk_100MHz.
- Reset values: segundos=0, minutos=0, horas=0, tick_1hz=0, dia_completo=0, prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while pause=0 and load=0.
  - At TICK_DIV-1 it wraps to 0 and asserts the internal advance enable for that cycle.
- Advance:
  - On an enable cycle, the time registers take their next values on the same edge that wraps the prescaler.
  - tick_1hz is registered and is high during the cycle in which the new time is visible. There is one cycle from enable to output.
  - After reset, the first advance happens TICK_DIV cycles after rst deasserts.
- Cascade:
  - segundos 59 -> 0 carries into minutos.
  - minutos 59 with carry -> 0 carries into horas.
  - horas 23 with carry -> 0, and dia_completo pulses alongside tick_1hz.
  - Otherwise the field increments by 1. Arithmetic is 6-bit unsigned.
- Pause (pause=1, load=0): time, prescaler and outputs all hold. The prescaler is NOT cleared, and no tick_1hz or dia_completo pulse is emitted.
- Load (load=1): highest priority, regardless of pause or a coincident advance.
  - Time registers take the *_load values on the next edge.
  - The prescaler is cleared to 0.
  - tick_1hz and dia_completo are 0 that cycle; a coincident advance is discarded.
  - The next advance occurs TICK_DIV cycles after the load edge, provided pause is low.
  - load arrives while pause is still high (final adjustment cycle); this is legal and the load is taken.
- Range protection on load: segundos_load>59 -> 0, minutos_load>59 -> 0, horas_load>23 -> 0. Each field is checked independently, so output range invariants always hold.
- Priority order: rst > load > pause > advance.
- No handshake back to the controller; load is fire-and-forget with a single-cycle pulse.

Decomposition:
- relogio_pkg, shared with the adjustment controller, holds:
  - MAX_SEG=59, MAX_MIN=59, MAX_HORA=23.
  - TIME_W=6.
  - A typedef for 6-bit time fields.
  - The adjustment-state enum, moved here so both blocks share it.
- One sub-module, divisor_tick: the parameterised prescaler.
  - Inputs: clk_100MHz, rst, hold (=pause), clear (=load).
  - Output: en (advance enable).
- The cascade and load logic stay in contador_relogio.

Test Plan:
1. Reset then free run, TICK_DIV=4: rst high 2 cycles then low -> 00:00:00 for 4 cycles; 00:00:01 with tick_1hz=1 for one cycle at cycle 4; 00:00:02 at cycle 8.
2. Load 00:00:58, free run -> 00:00:59 after 4 cycles, then 00:01:00 after 8; load 00:59:59 -> 01:00:00 after 4 cycles.
3. Day wrap: load 23:59:59 -> after 4 cycles 00:00:00, with tick_1hz=1 and dia_completo=1 in the same single cycle; dia_completo=0 on every other tick.
4. Pause mid-count: pause high for 20 cycles at prescaler=2 -> time frozen, no tick. After release, the advance occurs exactly 2 cycles later (prescaler resumed, not cleared).
5. Load with pause high, coincident with a would-be advance: pause=1, load=1 with values 12:34:56 -> outputs 12:34:56 next cycle, tick_1hz=0. After pause drops, 12:34:57 arrives 4 cycles after the load edge.
6. Out-of-range load 63:60:45 (horas=63, minutos=60, segundos=45) -> 00:00:45. rst asserted mid-run at 05:06:07 -> 00:00:00 on the next edge and the prescaler restarts.
